nmea_utc_parser: RTL and testbench
==================================

// Module: nmea_utc_parser
// PURPOSE
//  Downstream of the NMEA pattern search: consumes the byte stream following a matched header (e.g. "$GPRMC,").
//  Parses the UTC field "hhmmss[.f..f]," into binary hours/minutes/seconds/fraction.
//  Range-checks the result and flags malformed fields.
//  Feeds the time-tag logic with a one-cycle time_valid strobe per good sentence.
// PARAMETERS
//  FRAC_DIGITS  2  fractional-second digits expected after '.'; legal 0..3; 0 = no '.', ',' follows ss directly
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   synchronous reset, active low
//  pattern_found  in   1   level from pattern search; rising edge arms the parser
//  din            in   8   ASCII byte following the header
//  din_valid      in   1   din qualifier; one byte consumed per cycle when high
//  busy           out  1   high while armed and parsing
//  hours          out  5   0..23
//  minutes        out  6   0..59
//  seconds        out  6   0..60 (leap second allowed)
//  frac           out  10  fraction as integer of FRAC_DIGITS digits (e.g. ".50" -> 50)
//  time_valid     out  1   1-cycle strobe, outputs updated this cycle
//  parse_error    out  1   1-cycle strobe, field rejected
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE; all outputs 0; edge-detect reg 0.
//    A high pattern_found right after reset counts as a rising edge.
//  - Arming: pf_q <= pattern_found each cycle; arm = pattern_found & ~pf_q.
//    Arm in any state -> DIGITS, digit index 0, accumulators cleared, no error strobe.
//    Arming during a parse silently restarts it.
//  - States: IDLE, DIGITS, DOT, FRAC, COMMA. busy = (state != IDLE).
//  - Transitions happen only on din_valid=1; bytes with din_valid=0 are ignored, with no timeout.
//  - In IDLE, bytes are ignored.
//  - DIGITS: expects 6 bytes '0'..'9', stored as nibbles h1 h0 m1 m0 s1 s0.
//    After the 6th: FRAC_DIGITS>0 -> DOT, else -> COMMA.
//  - DOT: expects '.' -> FRAC, frac accumulator 0.
//  - FRAC: FRAC_DIGITS digits; acc <= acc*10 + digit, computed as (acc<<3)+(acc<<1)+d in 10 bits, no overflow for <=3 digits.
//    Then -> COMMA.
//  - COMMA: expects ','. Values: hh = h1*10+h0, mm = m1*10+m0, ss = s1*10+s0 (shift-add).
//    If hh<=23, mm<=59, ss<=60: register outputs and pulse time_valid.
//    Otherwise pulse parse_error and leave outputs unchanged. Either case -> IDLE.
//  - Any unexpected byte in DIGITS/DOT/FRAC/COMMA: parse_error pulses, -> IDLE.
//    Remaining bytes are ignored until the next arm.
//  - Latency: time_valid/parse_error assert the cycle after the offending or terminating byte is sampled.
//    Outputs change in that same cycle.
//  - time_valid and parse_error are never high together. Both are 0 except for single-cycle strobes.
//  - hours/minutes/seconds/frac hold their last good values until the next time_valid or reset.
//  - arm coinciding with a din_valid byte: arm wins; the byte is discarded.
//  - Reset mid-parse: IDLE immediately, outputs cleared, no strobe.
// TESTING
//  1. Arm, then "123519.00," (FRAC_DIGITS=2) -> time_valid 1 cycle after ','; hours=12 minutes=35 seconds=19 frac=0; busy 0.
//  2. "235960.99," -> valid, seconds=60, frac=99.
//     Then arm + "240000.00," -> parse_error; outputs stay 23/59/60/99.
//  3. Arm, "12a519.00," -> parse_error the cycle after 'a'; later bytes ignored; no time_valid.
//  4. Arm, "1235", drop and re-raise pattern_found, then "000102.50," -> valid 0/1/2/50; no parse_error.
//  5. Arm, "12", rst_n low 1 cycle -> all outputs 0, busy 0.
//     Then "3519.00," without re-arm -> no strobes.
//  6. Test 1 stream with random 0-3 idle cycles (din_valid=0, din=garbage) between bytes -> identical result.
//     Also FRAC_DIGITS=0 build with "010203," -> 1/2/3, frac=0.

Source files
------------

// File: rtl/nmea_utc_parser.sv
`default_nettype none
// ============================================================================
// Module      : nmea_utc_parser
// Description : Parses the NMEA UTC field "hhmmss[.f..f]," that follows a
//               matched sentence header into binary hours, minutes, seconds
//               and fraction. The field is range-checked. Malformed fields
//               raise a one-cycle parse_error strobe. A good field raises a
//               one-cycle time_valid strobe.
// Ports       : clk, rst_n       - clock, synchronous active-low reset
//               pattern_found    - header-match level; its rising edge arms
//               din, din_valid   - ASCII byte stream and qualifier
//               busy             - armed and parsing
//               hours/minutes/seconds/frac - last good time value
//               time_valid       - strobe: outputs updated this cycle
//               parse_error      - strobe: field rejected
// Revision    : 1.0 - initial release
// ============================================================================
module nmea_utc_parser #(
  parameter int FRAC_DIGITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pattern_found,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       busy,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [9:0] frac,
  output logic       time_valid,
  output logic       parse_error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIGITS = 3'd1,
    S_DOT    = 3'd2,
    S_FRAC   = 3'd3,
    S_COMMA  = 3'd4
  } state_t;

  // Index of the last fractional digit. It is unused when FRAC_DIGITS is 0.
  localparam logic [2:0] c_frac_last = (FRAC_DIGITS > 0) ? 3'(FRAC_DIGITS - 1) : 3'd0;
  localparam state_t     c_after_ss  = (FRAC_DIGITS > 0) ? S_DOT : S_COMMA;

  state_t     r_state;
  logic       r_pf_q;
  logic [2:0] r_idx;
  logic [3:0] r_nib [6];   // h1 h0 m1 m0 s1 s0
  logic [9:0] r_frac_acc;

  logic       w_arm;
  logic       w_is_digit;
  logic [3:0] w_digit;
  logic [6:0] w_hh;
  logic [6:0] w_mm;
  logic [6:0] w_ss;
  logic       w_time_ok;
  logic [9:0] w_frac_next;

  assign w_arm      = pattern_found & ~r_pf_q;
  assign w_is_digit = (din >= 8'h30) && (din <= 8'h39);
  assign w_digit    = din[3:0];   // ASCII '0'..'9' are 0x30..0x39

  // tens*10 + units as (tens<<3) + (tens<<1) + units
  assign w_hh = {r_nib[0], 3'b000} + {2'b00, r_nib[0], 1'b0} + {3'b000, r_nib[1]};
  assign w_mm = {r_nib[2], 3'b000} + {2'b00, r_nib[2], 1'b0} + {3'b000, r_nib[3]};
  assign w_ss = {r_nib[4], 3'b000} + {2'b00, r_nib[4], 1'b0} + {3'b000, r_nib[5]};

  // Seconds up to 60 so a leap second is accepted.
  assign w_time_ok = (w_hh <= 7'd23) && (w_mm <= 7'd59) && (w_ss <= 7'd60);

  // Ten bits are enough for three decimal digits (max 999).
  assign w_frac_next = (r_frac_acc << 3) + (r_frac_acc << 1) + {6'b000000, w_digit};

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pf_q      <= 1'b0;
      r_idx       <= 3'd0;
      r_frac_acc  <= 10'd0;
      for (int i = 0; i < 6; i++) r_nib[i] <= 4'd0;
      hours       <= 5'd0;
      minutes     <= 6'd0;
      seconds     <= 6'd0;
      frac        <= 10'd0;
      time_valid  <= 1'b0;
      parse_error <= 1'b0;
    end else begin
      r_pf_q      <= pattern_found;
      time_valid  <= 1'b0;
      parse_error <= 1'b0;
      if (w_arm) begin
        // Arming takes priority over any byte sampled in the same cycle and
        // silently restarts a parse already in progress.
        r_state    <= S_DIGITS;
        r_idx      <= 3'd0;
        r_frac_acc <= 10'd0;
        for (int i = 0; i < 6; i++) r_nib[i] <= 4'd0;
      end else if (din_valid) begin
        case (r_state)
          S_IDLE: ;
          S_DIGITS: begin
            if (w_is_digit) begin
              r_nib[r_idx] <= w_digit;
              if (r_idx == 3'd5) begin
                r_idx   <= 3'd0;
                r_state <= c_after_ss;
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end else begin
              parse_error <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          S_DOT: begin
            if (din == 8'h2E) begin
              r_state    <= S_FRAC;
              r_idx      <= 3'd0;
              r_frac_acc <= 10'd0;
            end else begin
              parse_error <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          S_FRAC: begin
            if (w_is_digit) begin
              r_frac_acc <= w_frac_next;
              if (r_idx == c_frac_last) begin
                r_state <= S_COMMA;
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end else begin
              parse_error <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          S_COMMA: begin
            if ((din == 8'h2C) && w_time_ok) begin
              hours      <= w_hh[4:0];
              minutes    <= w_mm[5:0];
              seconds    <= w_ss[5:0];
              frac       <= r_frac_acc;
              time_valid <= 1'b1;
            end else begin
              parse_error <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nmea_utc_parser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_nmea_utc_parser
// Description : Self-checking bench for nmea_utc_parser. Two instances share
//               the input stream: one with two fractional digits and one
//               with none.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nmea_utc_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pattern_found;
  logic [7:0] din;
  logic       din_valid;

  logic       busy, time_valid, parse_error;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic [9:0] frac;

  logic       busy0, time_valid0, parse_error0;
  logic [4:0] hours0;
  logic [5:0] minutes0, seconds0;
  logic [9:0] frac0;

  nmea_utc_parser #(.FRAC_DIGITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .pattern_found(pattern_found), .din(din),
    .din_valid(din_valid), .busy(busy), .hours(hours), .minutes(minutes),
    .seconds(seconds), .frac(frac), .time_valid(time_valid), .parse_error(parse_error)
  );

  nmea_utc_parser #(.FRAC_DIGITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pattern_found(pattern_found), .din(din),
    .din_valid(din_valid), .busy(busy0), .hours(hours0), .minutes(minutes0),
    .seconds(seconds0), .frac(frac0), .time_valid(time_valid0), .parse_error(parse_error0)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int both_high = 0;

  // Strobes observed during the last stream: count and index of the byte
  // after whose sampling edge the strobe appeared (-1 = during an idle gap).
  int tv_n, tv_pos, pe_n, pe_pos, tv0_n, tv0_pos, pe0_n, pe0_pos;

  // Last good time value expected on the FRAC_DIGITS=2 instance.
  int exp_h = 0, exp_m = 0, exp_s = 0, exp_f = 0;

  always @(negedge clk) begin
    if (time_valid && parse_error) both_high++;
    if (time_valid0 && parse_error0) both_high++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note(input int pos);
    if (time_valid)   begin tv_n++;  tv_pos  = pos; end
    if (parse_error)  begin pe_n++;  pe_pos  = pos; end
    if (time_valid0)  begin tv0_n++; tv0_pos = pos; end
    if (parse_error0) begin pe0_n++; pe0_pos = pos; end
  endtask

  task automatic send_stream(input string s, input int maxgap);
    int g;
    tv_n = 0; pe_n = 0; tv0_n = 0; pe0_n = 0;
    tv_pos = -9; pe_pos = -9; tv0_pos = -9; pe0_pos = -9;
    for (int i = 0; i < s.len(); i++) begin
      din = s[i];
      din_valid = 1'b1;
      tick();
      note(i);
      din_valid = 1'b0;
      g = $urandom_range(0, maxgap);
      for (int k = 0; k < g; k++) begin
        din = 8'($urandom);
        tick();
        note(-1);
      end
    end
    din_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      note(s.len() + k);
    end
  endtask

  task automatic arm();
    din_valid = 1'b0;
    pattern_found = 1'b0;
    tick();
    pattern_found = 1'b1;
    tick();
  endtask

  // Reference model working position-by-position on the text of the field:
  // kind 0 = no strobe yet, 1 = good time, 2 = rejected at byte index pos.
  function automatic void model(input string s, input int fd, output int kind,
                                output int pos, output int h, output int m,
                                output int sec, output int f);
    int len;
    int c;
    bit want_digit;
    byte want_char;
    len = 6 + ((fd > 0) ? fd + 1 : 0) + 1;
    kind = 0; pos = -9; h = 0; m = 0; sec = 0; f = 0;
    for (int i = 0; i < s.len() && i < len; i++) begin
      c = int'(s[i]);
      want_digit = 1'b0;
      want_char  = 8'h00;
      if (i < 6) want_digit = 1'b1;
      else if (i == len - 1) want_char = ",";
      else if (i == 6) want_char = ".";
      else want_digit = 1'b1;
      if (want_digit ? !(c >= 48 && c <= 57) : (c != int'(want_char))) begin
        kind = 2;
        pos  = i;
        return;
      end
    end
    if (s.len() < len) return;
    h   = (int'(s[0]) - 48) * 10 + (int'(s[1]) - 48);
    m   = (int'(s[2]) - 48) * 10 + (int'(s[3]) - 48);
    sec = (int'(s[4]) - 48) * 10 + (int'(s[5]) - 48);
    for (int i = 0; i < fd; i++) f = f * 10 + (int'(s[7 + i]) - 48);
    if (h <= 23 && m <= 59 && sec <= 60) kind = 1;
    else begin
      kind = 2;
      pos  = len - 1;
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; pattern_found = 1'b0; din_valid = 1'b0; din = 8'h00;
    tick(); tick();
    n_checks++;
    if ({busy, hours, minutes, seconds, frac, time_valid, parse_error} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0d h=%0d m=%0d s=%0d f=%0d tv=%0d pe=%0d, need all 0",
               busy, hours, minutes, seconds, frac, time_valid, parse_error);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %0d need 0", busy);
    end
  endtask

  task automatic test_basic();
    arm();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_armed: got %0d need 1", busy);
    end
    send_stream("123519.00,", 0);
    exp_h = 12; exp_m = 35; exp_s = 19; exp_f = 0;
    n_checks++;
    if (tv_n !== 1 || tv_pos !== 9 || pe_n !== 0) begin
      n_fail++;
      $display("FAIL basic_strobe: got tv_n=%0d tv_pos=%0d pe_n=%0d need 1/9/0", tv_n, tv_pos, pe_n);
    end
    n_checks++;
    if (hours !== 5'(exp_h) || minutes !== 6'(exp_m) || seconds !== 6'(exp_s) || frac !== 10'(exp_f) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_values: got %0d:%0d:%0d.%0d busy=%0d need 12:35:19.0 busy=0",
               hours, minutes, seconds, frac, busy);
    end
  endtask

  task automatic test_leap_range();
    arm();
    send_stream("235960.99,", 0);
    exp_h = 23; exp_m = 59; exp_s = 60; exp_f = 99;
    n_checks++;
    if (tv_n !== 1 || pe_n !== 0 || hours !== 5'(exp_h) || minutes !== 6'(exp_m) || seconds !== 6'(exp_s) || frac !== 10'(exp_f)) begin
      n_fail++;
      $display("FAIL leap_second: got tv_n=%0d pe_n=%0d %0d:%0d:%0d.%0d need 1/0 23:59:60.99",
               tv_n, pe_n, hours, minutes, seconds, frac);
    end
    arm();
    send_stream("240000.00,", 0);
    n_checks++;
    if (pe_n !== 1 || pe_pos !== 9 || tv_n !== 0) begin
      n_fail++;
      $display("FAIL hour_range_strobe: got pe_n=%0d pe_pos=%0d tv_n=%0d need 1/9/0", pe_n, pe_pos, tv_n);
    end
    n_checks++;
    if (hours !== 5'(exp_h) || minutes !== 6'(exp_m) || seconds !== 6'(exp_s) || frac !== 10'(exp_f)) begin
      n_fail++;
      $display("FAIL hour_range_hold: got %0d:%0d:%0d.%0d need 23:59:60.99", hours, minutes, seconds, frac);
    end
  endtask

  task automatic test_bad_char();
    arm();
    send_stream("12a519.00,", 0);
    n_checks++;
    if (pe_n !== 1 || pe_pos !== 2 || tv_n !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_char: got pe_n=%0d pe_pos=%0d tv_n=%0d busy=%0d need 1/2/0/0", pe_n, pe_pos, tv_n, busy);
    end
  endtask

  task automatic test_rearm();
    arm();
    send_stream("1235", 0);
    arm();
    send_stream("000102.50,", 0);
    exp_h = 0; exp_m = 1; exp_s = 2; exp_f = 50;
    n_checks++;
    if (tv_n !== 1 || tv_pos !== 9 || pe_n !== 0 || hours !== 5'(exp_h) || minutes !== 6'(exp_m) || seconds !== 6'(exp_s) || frac !== 10'(exp_f)) begin
      n_fail++;
      $display("FAIL rearm: got tv_n=%0d tv_pos=%0d pe_n=%0d %0d:%0d:%0d.%0d need 1/9/0 0:1:2.50",
               tv_n, tv_pos, pe_n, hours, minutes, seconds, frac);
    end
  endtask

  task automatic test_idle_gaps();
    arm();
    send_stream("123519.00,", 3);
    exp_h = 12; exp_m = 35; exp_s = 19; exp_f = 0;
    n_checks++;
    if (tv_n !== 1 || tv_pos !== 9 || pe_n !== 0 || hours !== 5'(exp_h) || minutes !== 6'(exp_m) || seconds !== 6'(exp_s) || frac !== 10'(exp_f)) begin
      n_fail++;
      $display("FAIL idle_gaps: got tv_n=%0d tv_pos=%0d pe_n=%0d %0d:%0d:%0d.%0d need 1/9/0 12:35:19.0",
               tv_n, tv_pos, pe_n, hours, minutes, seconds, frac);
    end
  endtask

  task automatic test_arm_collision();
    pattern_found = 1'b0;
    din_valid = 1'b0;
    tick();
    pattern_found = 1'b1;
    din = "9";
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    send_stream("074512.34,", 0);
    exp_h = 7; exp_m = 45; exp_s = 12; exp_f = 34;
    n_checks++;
    if (tv_n !== 1 || pe_n !== 0 || hours !== 5'(exp_h) || minutes !== 6'(exp_m) || seconds !== 6'(exp_s) || frac !== 10'(exp_f)) begin
      n_fail++;
      $display("FAIL arm_collision: got tv_n=%0d pe_n=%0d %0d:%0d:%0d.%0d need 1/0 7:45:12.34",
               tv_n, pe_n, hours, minutes, seconds, frac);
    end
  endtask

  task automatic test_reset_midparse();
    arm();
    send_stream("12", 0);
    rst_n = 1'b0;
    pattern_found = 1'b0;
    tick();
    exp_h = 0; exp_m = 0; exp_s = 0; exp_f = 0;
    n_checks++;
    if ({busy, hours, minutes, seconds, frac, time_valid, parse_error} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_midparse: got busy=%0d h=%0d m=%0d s=%0d f=%0d need all 0",
               busy, hours, minutes, seconds, frac);
    end
    rst_n = 1'b1;
    tick();
    send_stream("3519.00,", 0);
    n_checks++;
    if (tv_n !== 0 || pe_n !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_rearm_after_reset: got tv_n=%0d pe_n=%0d busy=%0d need 0/0/0", tv_n, pe_n, busy);
    end
    // pattern_found already high when reset releases arms the parser.
    rst_n = 1'b0;
    pattern_found = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    send_stream("123519.00,", 0);
    exp_h = 12; exp_m = 35; exp_s = 19; exp_f = 0;
    n_checks++;
    if (tv_n !== 1 || pe_n !== 0 || hours !== 5'(exp_h) || minutes !== 6'(exp_m) || seconds !== 6'(exp_s)) begin
      n_fail++;
      $display("FAIL arm_after_reset: got tv_n=%0d pe_n=%0d %0d:%0d:%0d need 1/0 12:35:19",
               tv_n, pe_n, hours, minutes, seconds);
    end
  endtask

  task automatic test_frac0();
    arm();
    send_stream("010203,", 1);
    n_checks++;
    if (tv0_n !== 1 || tv0_pos !== 6 || pe0_n !== 0 || hours0 !== 5'd1 || minutes0 !== 6'd2 || seconds0 !== 6'd3 || frac0 !== 10'd0) begin
      n_fail++;
      $display("FAIL frac0_valid: got tv_n=%0d tv_pos=%0d pe_n=%0d %0d:%0d:%0d.%0d need 1/6/0 1:2:3.0",
               tv0_n, tv0_pos, pe0_n, hours0, minutes0, seconds0, frac0);
    end
    n_checks++;
    if (pe_n !== 1 || pe_pos !== 6 || tv_n !== 0) begin
      n_fail++;
      $display("FAIL frac2_missing_dot: got pe_n=%0d pe_pos=%0d tv_n=%0d need 1/6/0", pe_n, pe_pos, tv_n);
    end
  endtask

  task automatic test_random();
    string s;
    int kind, pos, h, m, sec, f, len, sel;
    for (int it = 0; it < 60; it++) begin
      s = $sformatf("%02d%02d%02d.%02d,", $urandom_range(0, 29), $urandom_range(0, 65),
                    $urandom_range(0, 65), $urandom_range(0, 99));
      len = s.len();
      sel = $urandom_range(0, 3);
      if (sel == 0) s.putc($urandom_range(0, len - 1), byte'($urandom_range(32, 126)));
      else if (sel == 1) s = s.substr(0, $urandom_range(0, len - 2));
      model(s, 2, kind, pos, h, m, sec, f);
      arm();
      send_stream(s, $urandom_range(0, 2));
      if (kind == 1) begin
        exp_h = h; exp_m = m; exp_s = sec; exp_f = f;
      end
      n_checks++;
      if (!((kind == 0 && tv_n == 0 && pe_n == 0) ||
            (kind == 1 && tv_n == 1 && tv_pos == len - 1 && pe_n == 0) ||
            (kind == 2 && pe_n == 1 && pe_pos == pos && tv_n == 0))) begin
        n_fail++;
        $display("FAIL random_strobe \"%s\": got tv_n=%0d tv_pos=%0d pe_n=%0d pe_pos=%0d need kind=%0d pos=%0d",
                 s, tv_n, tv_pos, pe_n, pe_pos, kind, pos);
      end
      n_checks++;
      if (hours !== 5'(exp_h) || minutes !== 6'(exp_m) || seconds !== 6'(exp_s) || frac !== 10'(exp_f) ||
          busy !== (kind == 0)) begin
        n_fail++;
        $display("FAIL random_values \"%s\": got %0d:%0d:%0d.%0d busy=%0d need %0d:%0d:%0d.%0d busy=%0d",
                 s, hours, minutes, seconds, frac, busy, exp_h, exp_m, exp_s, exp_f, kind == 0);
      end
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_high !== 0) begin
      n_fail++;
      $display("FAIL strobes_exclusive: got %0d cycles with both strobes high, need 0", both_high);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leap_range();
    test_bad_char();
    test_rearm();
    test_idle_gaps();
    test_arm_collision();
    test_reset_midparse();
    test_frac0();
    test_random();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
